cobro_monedas: RTL
==================

Name: cobro_monedas

Overview:
Payment stage directly upstream of the coffee machine controller. It accepts coin pulses, accumulates credit against the price the machine publishes for a valid selection, and asserts PAGO_RECIBIDO to the machine once credit covers the price. It holds payment until the machine reports the drink is ready, then returns change. It also returns the full credit on cancel, loss of selection or (optionally) inactivity.

Parameters:
ANCHO_CREDITO, 5, width of credit/change registers (max reachable credit 24 fits in 5 bits)
TIMEOUT_CICLOS, 255, idle cycles in COBRANDO with credit > 0 before auto-refund (only with the optional feature; legal range 1..65535)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
moneda_valida  input  1  one-cycle pulse: a coin is present this cycle
moneda_valor  input  2  coin code: 00=1, 01=2, 10=5, 11=10 credit units
cancelar  input  1  user cancel request, level-sampled
precio  input  4  price from the machine, units
SELECCION_valida  input  1  machine reports a valid selection
listo  input  1  machine reports the drink is finished
PAGO_RECIBIDO  output  1  credit covers price; held until listo
credito  output  ANCHO_CREDITO  current accumulated credit (display)
vuelto  output  ANCHO_CREDITO  amount being returned; valid when vuelto_valido=1
vuelto_valido  output  1  one-cycle pulse: dispense vuelto now
moneda_rechazada  output  1  one-cycle pulse: the coin sampled last edge was returned unaccepted

Behaviour:
- All outputs registered. Reset (reset=0, async) forces state ESPERA, credito=0, vuelto=0, PAGO_RECIBIDO=0, vuelto_valido=0, moneda_rechazada=0, timeout counter=0. Release is synchronous to the next clk edge.
- States: ESPERA, COBRANDO, PAGADO, DEVOLUCION (2-bit encoding).
- ESPERA:
  - credito=0.
  - If SELECCION_valida=1 and precio!=0: capture precio into precio_reg and go to COBRANDO.
  - Any coin is rejected.
- COBRANDO, priority top-down:
  1. cancelar=1 or SELECCION_valida=0: a same-cycle coin is rejected. If credito>0, set vuelto=credito and go to DEVOLUCION; else go to ESPERA.
  2. Coin accepted: next credit = credito + value (no overflow, since credito < precio_reg <= 15 before the coin).
     - If next credit >= precio_reg: credito=next, vuelto=next-precio_reg, PAGO_RECIBIDO=1 from this edge, go to PAGADO.
     - Otherwise: credito=next and stay in COBRANDO.
  3. No coin: hold.
  - precio changes while in COBRANDO are ignored; precio_reg governs.
- PAGADO:
  - PAGO_RECIBIDO=1 and coins are rejected. cancelar and SELECCION_valida are ignored, because the drink is committed.
  - On listo=1: PAGO_RECIBIDO=0 and credito=0. If vuelto>0 go to DEVOLUCION; else go to ESPERA with vuelto=0.
- DEVOLUCION:
  - vuelto_valido=1 for exactly this one cycle, with vuelto stable. credito=0 and coins are rejected.
  - Next edge: go to ESPERA and clear vuelto to 0.
- moneda_rechazada: pulses the cycle after the edge at which a rejected coin was sampled.
- Latency: a coin sampled at edge N is visible in credito after edge N. PAGO_RECIBIDO rises after the same edge N as the paying coin.
- Reset mid-operation: credit is discarded with no refund pulse. The physical mechanism handles coin return; this is documented as a system-level limitation.

Optional Feature:
Macro COBRO_TIMEOUT_EN.
- When defined:
  - A 16-bit idle counter runs only in COBRANDO with credito>0. It clears on any accepted coin and on leaving COBRANDO.
  - On reaching TIMEOUT_CICLOS: vuelto=credito, go to DEVOLUCION, exactly as a cancel.
  - cancelar and a timeout in the same cycle are handled once, as a cancel.
- When not defined: no counter is present, and COBRANDO waits indefinitely.

Test Plan:
- precio=7, SELECCION_valida=1; coins 10(=5) then 01(=2) -> credito 5, then 7; PAGO_RECIBIDO=1 after the second coin edge. listo pulse -> PAGO_RECIBIDO=0, no vuelto_valido, back to ESPERA.
- precio=7; coins 5, 5 -> credito=10, PAGO_RECIBIDO=1. listo -> vuelto_valido pulse with vuelto=3, then credito=0.
- precio=9; coin 2, then cancelar=1 together with a coin of 5 -> moneda_rechazada pulse, vuelto_valido with vuelto=2, then ESPERA.
- SELECCION_valida=0; coin 10 -> moneda_rechazada=1 one cycle, credito stays 0. During PAGADO, a coin and cancelar -> coin rejected, PAGO_RECIBIDO stays 1.
- precio=12; coin 5, then reset=0 mid-cycle -> all outputs 0 immediately, state ESPERA, no vuelto_valido.
- With COBRO_TIMEOUT_EN, TIMEOUT_CICLOS=4; precio=9, coin 1, then idle -> vuelto_valido with vuelto=1 exactly 4 cycles after the coin edge. Without the macro, no refund occurs.

Source files
------------

// File: rtl/cobro_monedas_if.sv
// Coin/payment bus between the machine-side logic and the cobro_monedas stage.
interface cobro_monedas_if #(
  parameter int ANCHO_CREDITO = 5
);
  logic                     moneda_valida;
  logic [1:0]               moneda_valor;
  logic                     cancelar;
  logic [3:0]               precio;
  logic                     SELECCION_valida;
  logic                     listo;
  logic                     PAGO_RECIBIDO;
  logic [ANCHO_CREDITO-1:0] credito;
  logic [ANCHO_CREDITO-1:0] vuelto;
  logic                     vuelto_valido;
  logic                     moneda_rechazada;

  modport slave (
    input  moneda_valida, moneda_valor, cancelar, precio, SELECCION_valida, listo,
    output PAGO_RECIBIDO, credito, vuelto, vuelto_valido, moneda_rechazada
  );

  modport master (
    output moneda_valida, moneda_valor, cancelar, precio, SELECCION_valida, listo,
    input  PAGO_RECIBIDO, credito, vuelto, vuelto_valido, moneda_rechazada
  );
endinterface

// File: rtl/cobro_monedas.sv
// Coin payment stage: accumulates credit against the selected price, holds payment until the
// drink is ready, then returns change. Optional inactivity refund enabled by COBRO_TIMEOUT_EN.
module cobro_monedas #(
  parameter int ANCHO_CREDITO  = 5,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic            clk,
  input  logic            reset,
  cobro_monedas_if.slave  bus
);

  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    COBRANDO   = 2'd1,
    PAGADO     = 2'd2,
    DEVOLUCION = 2'd3
  } estado_t;

  function automatic logic [ANCHO_CREDITO-1:0] valor_moneda(input logic [1:0] codigo);
    case (codigo)
      2'b00:   valor_moneda = ANCHO_CREDITO'(1);
      2'b01:   valor_moneda = ANCHO_CREDITO'(2);
      2'b10:   valor_moneda = ANCHO_CREDITO'(5);
      default: valor_moneda = ANCHO_CREDITO'(10);
    endcase
  endfunction

  estado_t                  r_estado, w_estado_sig;
  logic [3:0]               r_precio, w_precio_sig;
  logic [ANCHO_CREDITO-1:0] r_credito, w_credito_sig;
  logic [ANCHO_CREDITO-1:0] r_vuelto, w_vuelto_sig;
  logic                     r_pago, w_pago_sig;
  logic                     r_vuelto_valido;
  logic                     r_rechazo, w_rechazo_sig;
  logic                     w_acepta;
  logic                     w_timeout;
  logic [ANCHO_CREDITO-1:0] w_suma;
  logic [ANCHO_CREDITO-1:0] w_precio_ext;

  // Credit is always below the price (<=15) before a coin, so the sum never exceeds 24.
  assign w_suma       = r_credito + valor_moneda(bus.moneda_valor);
  assign w_precio_ext = ANCHO_CREDITO'(r_precio);

`ifdef COBRO_TIMEOUT_EN
  logic [15:0] r_cnt_inactivo;

  assign w_timeout = (r_estado == COBRANDO) && (r_credito != '0) &&
                     (r_cnt_inactivo == 16'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_inactivo <= '0;
    end else if (r_estado == COBRANDO && w_estado_sig == COBRANDO &&
                 r_credito != '0 && !w_acepta) begin
      r_cnt_inactivo <= r_cnt_inactivo + 16'd1;
    end else begin
      r_cnt_inactivo <= '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CICLOS == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_estado_sig  = r_estado;
    w_precio_sig  = r_precio;
    w_credito_sig = r_credito;
    w_vuelto_sig  = r_vuelto;
    w_pago_sig    = r_pago;
    w_rechazo_sig = 1'b0;
    w_acepta      = 1'b0;
    case (r_estado)
      ESPERA: begin
        w_credito_sig = '0;
        w_rechazo_sig = bus.moneda_valida;
        if (bus.SELECCION_valida && bus.precio != 4'd0) begin
          w_precio_sig = bus.precio;
          w_estado_sig = COBRANDO;
        end
      end
      COBRANDO: begin
        if (bus.cancelar || !bus.SELECCION_valida) begin
          w_rechazo_sig = bus.moneda_valida;
          w_credito_sig = '0;
          if (r_credito != '0) begin
            w_vuelto_sig = r_credito;
            w_estado_sig = DEVOLUCION;
          end else begin
            w_estado_sig = ESPERA;
          end
        end else if (bus.moneda_valida) begin
          w_acepta      = 1'b1;
          w_credito_sig = w_suma;
          if (w_suma >= w_precio_ext) begin
            w_vuelto_sig = w_suma - w_precio_ext;
            w_pago_sig   = 1'b1;
            w_estado_sig = PAGADO;
          end
        end else if (w_timeout) begin
          w_vuelto_sig  = r_credito;
          w_credito_sig = '0;
          w_estado_sig  = DEVOLUCION;
        end
      end
      PAGADO: begin
        // Drink is committed: cancel and loss of selection no longer matter here.
        w_rechazo_sig = bus.moneda_valida;
        w_pago_sig    = 1'b1;
        if (bus.listo) begin
          w_pago_sig    = 1'b0;
          w_credito_sig = '0;
          if (r_vuelto != '0) begin
            w_estado_sig = DEVOLUCION;
          end else begin
            w_vuelto_sig = '0;
            w_estado_sig = ESPERA;
          end
        end
      end
      DEVOLUCION: begin
        w_rechazo_sig = bus.moneda_valida;
        w_credito_sig = '0;
        w_vuelto_sig  = '0;
        w_estado_sig  = ESPERA;
      end
      default: begin
        w_estado_sig = ESPERA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado        <= ESPERA;
      r_precio        <= '0;
      r_credito       <= '0;
      r_vuelto        <= '0;
      r_pago          <= 1'b0;
      r_vuelto_valido <= 1'b0;
      r_rechazo       <= 1'b0;
    end else begin
      r_estado        <= w_estado_sig;
      r_precio        <= w_precio_sig;
      r_credito       <= w_credito_sig;
      r_vuelto        <= w_vuelto_sig;
      r_pago          <= w_pago_sig;
      r_vuelto_valido <= (w_estado_sig == DEVOLUCION);
      r_rechazo       <= w_rechazo_sig;
    end
  end

  assign bus.PAGO_RECIBIDO    = r_pago;
  assign bus.credito          = r_credito;
  assign bus.vuelto           = r_vuelto;
  assign bus.vuelto_valido    = r_vuelto_valido;
  assign bus.moneda_rechazada = r_rechazo;

endmodule
